mips32_mem_responder: RTL

Memory-side responder for the MIPS32 core: a single-clock, word-addressed 1024×32 unified memory that services instruction-fetch reads and data load/store requests through a req/ack handshake. It replaces direct array access by the IF and MEM stages and inserts a programmable number of wait states. An arbiter alternates priority between the two ports so that neither port starves.

---
 rtl/mips32_mem_responder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mips32_mem_responder.sv
// mips32_mem_responder
// Memory-side responder for the MIPS32 core. A single-clock, word-addressed
// DEPTH x 32 unified memory serves instruction-fetch reads and data
// load/store requests through a req/ack handshake. A fixed number of wait
// states precedes every access. When both ports request at once, priority
// alternates so that neither port can starve.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two)
//   AW          log2(DEPTH), word-index bits taken from the address
//   WAIT_CYCLES wait states inserted before each access (0..15)
//
// Ports:
//   clk1        single clock, rising edge
//   rst         synchronous active-high reset
//   if_req      fetch request, held until if_ack
//   if_addr     fetch word address
//   if_ack      one-cycle ack pulse, if_rdata valid in the same cycle
//   if_rdata    fetched word, holds between acks
//   d_req       data request, held until d_ack
//   d_we        1 = store, 0 = load
//   d_addr      data word address
//   d_wdata     store data
//   d_ack       one-cycle ack pulse, d_rdata valid in the same cycle
//   d_rdata     loaded word (0 for a store), holds between acks
//   err         address fault flag, valid with an ack pulse
//
// Build option:
//   MEM_FAULT_EN  when defined, any nonzero address bit above AW-1 makes the
//                 access fault: err = 1, no write, rdata = 0. When undefined,
//                 err is always 0 and addresses wrap modulo DEPTH.

module mips32_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err
);

    localparam int unsigned DW     = 32;
    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    // Request captured at grant time; the access uses only these values.
    typedef struct packed {
        port_t          port;
        logic           we;
        logic [DW-1:0]  addr;
        logic [DW-1:0]  wdata;
    } req_t;

    state_t              state;
    state_t              state_nxt;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wcnt_nxt;
    port_t               last_grant;
    port_t               last_grant_nxt;
    req_t                lat;
    req_t                lat_nxt;

    logic                if_ack_nxt;
    logic                d_ack_nxt;
    logic [DW-1:0]       if_rdata_nxt;
    logic [DW-1:0]       d_rdata_nxt;
    logic                err_nxt;

    logic                grant_d_c;
    logic                fault_c;
    logic                mem_we_c;
    logic [AW-1:0]       mem_idx_c;
    logic [DW-1:0]       mem_rd_c;

    // Memory array; never reset, contents come only from stores.
    logic [DW-1:0]       mem [DEPTH];

    // Data port wins a tie unless it was the last port served.
    assign grant_d_c = d_req && (!if_req || (last_grant != PORT_D));

    assign mem_idx_c = lat.addr[AW-1:0];
    assign mem_rd_c  = mem[mem_idx_c];

`ifdef MEM_FAULT_EN
    // Any address bit above the index range is a fault.
    assign fault_c = |lat.addr[DW-1:AW];
`else
    // High address bits are ignored so addresses alias modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^lat.addr[DW-1:AW];
    assign fault_c        = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk1) begin : state_reg
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            last_grant <= PORT_IF;
            lat        <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            last_grant <= last_grant_nxt;
            lat        <= lat_nxt;
            if_ack     <= if_ack_nxt;
            d_ack      <= d_ack_nxt;
            if_rdata   <= if_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            err        <= err_nxt;
        end
    end

    // Next-state, grant capture and access decode.
    always_comb begin : fsm_next
        state_nxt      = state;
        wcnt_nxt       = wcnt;
        last_grant_nxt = last_grant;
        lat_nxt        = lat;
        if_ack_nxt     = 1'b0;
        d_ack_nxt      = 1'b0;
        if_rdata_nxt   = if_rdata;
        d_rdata_nxt    = d_rdata;
        err_nxt        = 1'b0;
        mem_we_c       = 1'b0;

        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    lat_nxt.port   = grant_d_c ? PORT_D : PORT_IF;
                    lat_nxt.we     = grant_d_c && d_we;
                    lat_nxt.addr   = grant_d_c ? d_addr : if_addr;
                    lat_nxt.wdata  = grant_d_c ? d_wdata : '0;
                    last_grant_nxt = grant_d_c ? PORT_D : PORT_IF;
                    wcnt_nxt       = WCNT_W'(WAIT_CYCLES);
                    state_nxt      = WAIT;
                end
            end

            WAIT: begin
                if (wcnt != '0) begin
                    wcnt_nxt = wcnt - WCNT_W'(1);
                end else begin
                    // Access edge: result lands together with the ack.
                    err_nxt   = fault_c;
                    state_nxt = RESP;
                    if (lat.port == PORT_D) begin
                        d_ack_nxt = 1'b1;
                        if (fault_c) begin
                            d_rdata_nxt = '0;
                        end else if (lat.we) begin
                            d_rdata_nxt = '0;
                            mem_we_c    = 1'b1;
                        end else begin
                            d_rdata_nxt = mem_rd_c;
                        end
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = fault_c ? '0 : mem_rd_c;
                    end
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Store port; reset on the access edge suppresses the write.
    always_ff @(posedge clk1) begin : mem_write
        if (!rst && mem_we_c) begin
            mem[mem_idx_c] <= lat.wdata;
        end
    end

endmodule
